// File: rtl/and_resource_arbiter_pkg.sv
// Shared definitions for the AND resource arbiter: FSM encoding and the
// ceil-log2 helper used to size ids and the occupancy counter.
package and_resource_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/and_arb_rr_pick.sv
// Round-robin picker: first requester at or after ptr+1, wrapping mod NREQ.
module and_arb_rr_pick
    import and_resource_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  sel
);

    always_comb begin
        int idx;
        any = 1'b0;
        sel = '0;
        idx = 0;
        // Walk the rotated vector; the first hit wins and later hits are ignored.
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + 1 + k) % NREQ;
            if (!any && req[idx]) begin
                any = 1'b1;
                sel = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/and_resource_arbiter.sv
// Shares one multi-cycle AND operator between NREQ requesters: grants one at a
// time in round-robin order, captures its operands and returns a tagged result.
module and_resource_arbiter
    import and_resource_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DELAY = 3,
    parameter int IDW   = clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] in1,
    input  logic [NREQ*WIDTH-1:0] in2,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  out_valid,
    output logic [IDW-1:0]        out_id,
    output logic [WIDTH-1:0]      out,
    output state_t                dbg_state
);

    localparam int CW = clog2(DELAY + 1);

    // Handshake: a requester holds req high until it sees its one-cycle gnt;
    // req is only sampled in IDLE, and a level still high on return to IDLE
    // is treated as a fresh request.

    state_t            state;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    cur_id;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic              any;
    logic [IDW-1:0]    sel;

    and_arb_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .any (any),
        .sel (sel)
    );

    assign dbg_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= IDW'(NREQ - 1);
            cur_id    <= '0;
            cnt       <= '0;
            opa       <= '0;
            opb       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out       <= '0;
        end else begin
            gnt       <= '0;
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        gnt    <= NREQ'(1) << sel;
                        opa    <= in1[int'(sel)*WIDTH +: WIDTH];
                        opb    <= in2[int'(sel)*WIDTH +: WIDTH];
                        cur_id <= sel;
                        ptr    <= sel;
                        cnt    <= CW'(DELAY);
                        state  <= ST_BUSY;
                        busy   <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    // cnt reaches 1 on the edge that ends the occupancy window.
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        out       <= opa & opb;
                        out_id    <= cur_id;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
